// File: rtl/instr_fetch_responder_pkg.sv
// instr_fetch_responder_pkg: shared widths, constants, response record and address checks for the fetch responder
package instr_fetch_responder_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0000;
    localparam int FETCH_LAT_MAX = 4;

    typedef struct packed {
        logic err;
        logic [INSTR_WIDTH-1:0] addr;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_rsp_t;

    function automatic logic addr_oob(input logic [INSTR_WIDTH-1:0] a, input int depth_log2);
        return (a >> (depth_log2 + 2)) != '0;
    endfunction

    function automatic logic addr_bad(input logic [INSTR_WIDTH-1:0] a, input int depth_log2);
        return (a[1:0] != 2'b00) || addr_oob(a, depth_log2);
    endfunction

endpackage

// File: rtl/instr_fetch_responder_fifo.sv
// fetch_rsp_fifo: in-order response queue with synchronous flush; head is shown combinationally
module fetch_rsp_fifo
    import instr_fetch_responder_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  fetch_rsp_t                push_data,
    input  logic                      pop,
    output fetch_rsp_t                head,
    output logic [$clog2(QDEPTH):0]   count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    fetch_rsp_t mem [QDEPTH];
    logic [PW-1:0] wp, rp;

    assign head = mem[rp];

    // storage needs no reset; the top masks the head while the queue is empty
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_data;
    end

    // pointers wrap naturally modulo QDEPTH; flush empties the queue after any same-edge pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + PW'(push);
            rp    <= rp + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: instruction RAM responder with fixed-latency pipeline, ordered response queue and flush
module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2,
    parameter int QDEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   W_req_valid,
    output logic                   W_req_ready,
    input  logic [INSTR_WIDTH-1:0] W_req_addr,
    input  logic                   W_flush,
    output logic                   W_rsp_valid,
    input  logic                   W_rsp_ready,
    output logic [INSTR_WIDTH-1:0] W_rsp_instr,
    output logic [INSTR_WIDTH-1:0] W_rsp_addr,
    output logic                   W_rsp_err,
    input  logic                   W_wr_en,
    input  logic [INSTR_WIDTH-1:0] W_wr_addr,
    input  logic [INSTR_WIDTH-1:0] W_wr_data
);

    localparam int CW    = $clog2(QDEPTH) + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    if (LATENCY < 1 || LATENCY > FETCH_LAT_MAX || QDEPTH < LATENCY) begin : g_bad_params
        $error("instr_fetch_responder: unsupported LATENCY/QDEPTH combination");
    end

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] rd_q;
    logic [LATENCY-1:0]     sv;
    fetch_rsp_t             sp  [LATENCY];
    fetch_rsp_t             cur [LATENCY];
    fetch_rsp_t             head;
    logic [CW-1:0]          cnt, fifo_count;
    logic                   acc, pop, req_err, wr_ok;

    assign W_req_ready = cnt < CW'(QDEPTH);
    assign acc         = W_req_valid & W_req_ready;
    assign req_err     = addr_bad(W_req_addr, DEPTH_LOG2);
    assign wr_ok       = W_wr_en & ~addr_oob(W_wr_addr, DEPTH_LOG2);
    assign W_rsp_valid = fifo_count != '0;
    assign pop         = W_rsp_valid & W_rsp_ready;
    assign {W_rsp_err, W_rsp_addr, W_rsp_instr} = W_rsp_valid ? head : '0;

    // single-port-style RAM: read-first, and erroneous fetches never touch the array
    always_ff @(posedge clk) begin
        if (wr_ok) mem[W_wr_addr[DEPTH_LOG2+1:2]] <= W_wr_data;
        if (acc && !req_err) rd_q <= mem[W_req_addr[DEPTH_LOG2+1:2]];
    end

    // stage 0 gets its instruction from the RAM output register rather than its own payload
    always_comb begin
        for (int k = 0; k < LATENCY; k++) cur[k] = sp[k];
        cur[0].instr = sp[0].err ? INSTR_NOP : rd_q;
    end

    // non-stalling latency pipeline; a flush kills everything except the request accepted on that edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sv <= '0;
            for (int k = 0; k < LATENCY; k++) sp[k] <= '0;
        end else begin
            sv[0] <= acc;
            if (acc) sp[0] <= '{err: req_err, addr: W_req_addr, instr: INSTR_NOP};
            for (int k = 1; k < LATENCY; k++) begin
                sv[k] <= sv[k-1] & ~W_flush;
                sp[k] <= cur[k-1];
            end
        end
    end

    fetch_rsp_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (W_flush),
        .push      (sv[LATENCY-1] & ~W_flush),
        .push_data (cur[LATENCY-1]),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // outstanding = pipeline + queue entries; space is reserved at accept so the queue never overflows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else cnt <= W_flush ? CW'(acc) : cnt + CW'(acc) - CW'(pop);
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// tb_instr_fetch_responder: directed tests against a queue-based reference model of the fetch responder
module tb_instr_fetch_responder;

    localparam int LAT = 2;
    localparam int QD  = 4;
    localparam int DL2 = 10;

    logic        clk = 0, rst = 0;
    logic        W_req_valid = 0, W_flush = 0, W_rsp_ready = 0, W_wr_en = 0;
    logic [31:0] W_req_addr = 0, W_wr_addr = 0, W_wr_data = 0;
    logic        W_req_ready, W_rsp_valid, W_rsp_err;
    logic [31:0] W_rsp_instr, W_rsp_addr;

    instr_fetch_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .W_req_valid(W_req_valid), .W_req_ready(W_req_ready), .W_req_addr(W_req_addr),
        .W_flush(W_flush),
        .W_rsp_valid(W_rsp_valid), .W_rsp_ready(W_rsp_ready), .W_rsp_instr(W_rsp_instr),
        .W_rsp_addr(W_rsp_addr), .W_rsp_err(W_rsp_err),
        .W_wr_en(W_wr_en), .W_wr_addr(W_wr_addr), .W_wr_data(W_wr_data)
    );

    always #5 clk = ~clk;

    int n_run = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: expected responses with the cycle each becomes visible
    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [1024];
    int          cyc = 0;
    logic        m_pop, m_acc, m_bad;

    // advance the model on every clock edge; reset empties it
    always @(posedge clk or negedge rst) begin
        if (!rst) q.delete();
        else begin
            m_pop = q.size() > 0 && q[0].due <= cyc && W_rsp_ready;
            m_acc = W_req_valid && q.size() < QD;
            m_bad = (W_req_addr % 4 != 0) || (W_req_addr >= 4 * (1 << DL2));
            cyc++;
            if (m_pop) void'(q.pop_front());
            if (W_flush) q.delete();
            if (m_acc) q.push_back('{cyc + LAT, W_req_addr, m_bad ? 32'h0 : mm[(W_req_addr >> 2) & 32'h3FF], m_bad});
            if (W_wr_en && W_wr_addr < 4 * (1 << DL2)) mm[(W_wr_addr >> 2) & 32'h3FF] = W_wr_data;
        end
    end

    // compare DUT outputs with the model on every falling edge
    always @(negedge clk) begin : cmp
        logic mv;
        mv = q.size() > 0 && q[0].due <= cyc;
        chk("m_ready", W_req_ready, q.size() < QD);
        chk("m_valid", W_rsp_valid, mv);
        if (mv && W_rsp_valid) begin
            chk("m_instr", W_rsp_instr, q[0].instr);
            chk("m_addr", W_rsp_addr, q[0].addr);
            chk("m_err", W_rsp_err, q[0].err);
        end
    end

    logic [31:0] e_addr [3];
    logic [31:0] e_instr [3];
    logic        e_err [3];

    initial begin
        tick();
        tick();
        rst = 1;
        chk("rst_valid", W_rsp_valid, 0);
        chk("rst_instr", W_rsp_instr, 0);
        chk("rst_addr", W_rsp_addr, 0);
        chk("rst_err", W_rsp_err, 0);
        chk("rst_ready", W_req_ready, 1);

        // preload program words
        for (int i = 0; i < 8; i++) begin
            W_wr_en = 1; W_wr_addr = 4 * i; W_wr_data = 32'h1111_0000 + i;
            tick();
        end
        W_wr_addr = 32'h40; W_wr_data = 32'hCAFE_0040;
        tick();
        W_wr_en = 0;

        // single fetch
        W_rsp_ready = 1; W_req_valid = 1; W_req_addr = 32'h4;
        tick();
        W_req_valid = 0;
        chk("t1_lat0", W_rsp_valid, 0);
        tick();
        chk("t1_lat1", W_rsp_valid, 0);
        tick();
        chk("t1_valid", W_rsp_valid, 1);
        chk("t1_instr", W_rsp_instr, 32'h1111_0001);
        chk("t1_addr", W_rsp_addr, 32'h4);
        chk("t1_err", W_rsp_err, 0);
        chk("t1_ready", W_req_ready, 1);
        repeat (3) tick();

        // streaming
        for (int k = 0; k < 6; k++) begin
            W_req_valid = k < 4; W_req_addr = 4 * k;
            tick();
            if (k >= 2) begin
                chk("t2_valid", W_rsp_valid, 1);
                chk("t2_addr", W_rsp_addr, 4 * (k - 2));
                chk("t2_instr", W_rsp_instr, 32'h1111_0000 + k - 2);
            end
        end
        W_req_valid = 0;
        tick();
        chk("t2_drain", W_rsp_valid, 0);
        repeat (2) tick();

        // backpressure
        W_rsp_ready = 0;
        for (int k = 0; k < 6; k++) begin
            W_req_valid = 1; W_req_addr = 4 * k;
            tick();
            chk("t3_ready", W_req_ready, k < 3);
        end
        W_req_valid = 0;
        chk("t3_head", W_rsp_addr, 32'h0);
        repeat (2) tick();
        chk("t3_hold_addr", W_rsp_addr, 32'h0);
        chk("t3_hold_instr", W_rsp_instr, 32'h1111_0000);
        W_rsp_ready = 1;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t3_ready_back", W_req_ready, 1);
            chk("t3_order", W_rsp_addr, 4 * k);
        end
        tick();
        chk("t3_empty", W_rsp_valid, 0);
        repeat (2) tick();

        // flush with a redirect fetch in the same cycle
        W_rsp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            W_req_valid = 1; W_req_addr = 4 * k;
            tick();
        end
        W_flush = 1; W_req_addr = 32'h40;
        tick();
        W_flush = 0; W_req_valid = 0;
        chk("t4_dropped", W_rsp_valid, 0);
        tick();
        chk("t4_wait", W_rsp_valid, 0);
        tick();
        chk("t4_valid", W_rsp_valid, 1);
        chk("t4_addr", W_rsp_addr, 32'h40);
        chk("t4_instr", W_rsp_instr, 32'hCAFE_0040);
        W_rsp_ready = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_gone", W_rsp_valid, 0);
        end

        // errors, then a good fetch
        e_addr  = '{32'h6, 32'h1000, 32'h8};
        e_instr = '{32'h0, 32'h0, 32'h1111_0002};
        e_err   = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            W_req_valid = k < 3; W_req_addr = k < 3 ? e_addr[k] : 32'h0;
            tick();
            if (k >= 2) begin
                chk("t5_addr", W_rsp_addr, e_addr[k-2]);
                chk("t5_instr", W_rsp_instr, e_instr[k-2]);
                chk("t5_err", W_rsp_err, e_err[k-2]);
            end
        end
        W_req_valid = 0;
        repeat (2) tick();

        // reset with requests outstanding
        W_rsp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            W_req_valid = 1; W_req_addr = 4 * k;
            tick();
        end
        W_req_valid = 0;
        chk("t6_pre", W_rsp_valid, 1);
        rst = 0;
        #1;
        chk("t6_valid", W_rsp_valid, 0);
        chk("t6_instr", W_rsp_instr, 0);
        chk("t6_addr", W_rsp_addr, 0);
        chk("t6_err", W_rsp_err, 0);
        tick();
        rst = 1;
        chk("t6_ready", W_req_ready, 1);

        // read-first on a same-cycle write to the fetched word
        W_wr_en = 1; W_wr_addr = 32'h8; W_wr_data = 32'hDEAD_BEEF;
        W_req_valid = 1; W_req_addr = 32'h8; W_rsp_ready = 1;
        tick();
        W_wr_en = 0;
        tick();
        W_req_valid = 0;
        tick();
        chk("t6_old", W_rsp_instr, 32'h1111_0002);
        tick();
        chk("t6_new", W_rsp_instr, 32'hDEAD_BEEF);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
